// File: rtl/hcsr04_scan_scheduler.sv
// hcsr04_scan_scheduler
// Round-robin scheduler for up to four HC-SR04 ultrasonic rangers. Each
// enabled sensor is triggered in turn, its echo pulse width is measured in
// clock ticks, and one result strobe is issued per trigger. A guard gap
// follows every measurement so that late echoes die out before the next ping.
//
// Ports
//   Clock          system clock, all logic on the rising edge
//   Reset          synchronous active-high reset
//   run            1 = keep scanning, 0 = halt after the current measurement
//   en_mask[3:0]   per-sensor enable for the rotation
//   echo_in[3:0]   raw asynchronous echo lines
//   trig_out[3:0]  trigger lines, at most one high
//   result_valid   one-cycle strobe qualifying the result_* fields
//   result_timeout 1 = no echo rise seen or echo width saturated
//   result_id      sensor index of the result
//   result_ticks   echo width in clock ticks
//   busy           high whenever the scheduler is not idle
module hcsr04_scan_scheduler #(
   parameter int unsigned TRIG_CYCLES  = 500,
   parameter int unsigned RISE_TIMEOUT = 100000,
   parameter int unsigned ECHO_MAX     = 1900000,
   parameter int unsigned GUARD_CYCLES = 3000000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        run,
   input  logic [3:0]  en_mask,
   input  logic [3:0]  echo_in,
   output logic [3:0]  trig_out,
   output logic        result_valid,
   output logic        result_timeout,
   output logic [1:0]  result_id,
   output logic [20:0] result_ticks,
   output logic        busy
);

   localparam int unsigned CW = 22;

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GUARD} state_t;

   state_t         state, state_next;
   logic [3:0]     echo_m, echo_s, echo_d;
   logic [CW-1:0]  cnt, cnt_next;
   logic [1:0]     sel, sel_next;
   logic [1:0]     last_id, last_id_next;
   logic [1:0]     pick, idx;
   logic           found;
   logic           echo_cur, echo_rise;
   logic           res_valid_next, res_timeout_next;
   logic [1:0]     res_id_next;
   logic [20:0]    res_ticks_next;

   // echo_d holds the previous synchronized sample of every line, so a line
   // that is already high when WAIT_RISE is entered never looks like a rise.
   assign echo_cur  = echo_s[sel];
   assign echo_rise = echo_s[sel] & ~echo_d[sel];

   // Next enabled index strictly after last_id; k=4 wraps back to last_id
   // itself, which covers a mask with a single enabled sensor.
   always_comb begin
      pick  = last_id;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = last_id + 2'(k);
         if (!found && en_mask[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      sel_next         = sel;
      last_id_next     = last_id;
      res_valid_next   = 1'b0;
      res_timeout_next = result_timeout;
      res_id_next      = result_id;
      res_ticks_next   = result_ticks;
      case (state)
         IDLE: begin
            if (run && (en_mask != 4'b0000)) begin
               sel_next   = pick;
               cnt_next   = '0;
               state_next = TRIG;
            end
         end
         TRIG: begin
            if (cnt == CW'(TRIG_CYCLES - 1)) begin
               cnt_next   = '0;
               state_next = WAIT_RISE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         WAIT_RISE: begin
            if (echo_rise) begin
               cnt_next   = CW'(1);
               state_next = MEASURE;
            end else if (cnt == CW'(RISE_TIMEOUT - 1)) begin
               res_valid_next   = 1'b1;
               res_timeout_next = 1'b1;
               res_id_next      = sel;
               res_ticks_next   = '0;
               cnt_next         = '0;
               state_next       = GUARD;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         MEASURE: begin
            if (!echo_cur) begin
               res_valid_next   = 1'b1;
               res_timeout_next = 1'b0;
               res_id_next      = sel;
               res_ticks_next   = cnt[20:0];
               cnt_next         = '0;
               state_next       = GUARD;
            end else if (cnt == CW'(ECHO_MAX)) begin
               res_valid_next   = 1'b1;
               res_timeout_next = 1'b1;
               res_id_next      = sel;
               res_ticks_next   = cnt[20:0];
               cnt_next         = '0;
               state_next       = GUARD;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         GUARD: begin
            if (cnt == CW'(GUARD_CYCLES - 1)) begin
               last_id_next = sel;
               cnt_next     = '0;
               state_next   = IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state          <= IDLE;
         cnt            <= '0;
         sel            <= '0;
         last_id        <= 2'd3;
         echo_m         <= '0;
         echo_s         <= '0;
         echo_d         <= '0;
         result_valid   <= 1'b0;
         result_timeout <= 1'b0;
         result_id      <= '0;
         result_ticks   <= '0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         sel            <= sel_next;
         last_id        <= last_id_next;
         echo_m         <= echo_in;
         echo_s         <= echo_m;
         echo_d         <= echo_s;
         result_valid   <= res_valid_next;
         result_timeout <= res_timeout_next;
         result_id      <= res_id_next;
         result_ticks   <= res_ticks_next;
      end
   end

   always_comb begin
      trig_out = '0;
      if (state == TRIG) trig_out[sel] = 1'b1;
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/hcsr04_scan_scheduler.md
HCSR04_SCAN_SCHEDULER -- requirements
Module: hcsr04_scan_scheduler

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 500, trigger pulse length in clocks (10 us at 50 MHz).
REQ-002 SHALL have parameter RISE_TIMEOUT, default 100000, max clocks from trigger end to echo rising edge.
REQ-003 SHALL have parameter ECHO_MAX, default 1900000, echo width saturation limit in clocks (must be < 2^21).
REQ-004 SHALL have parameter GUARD_CYCLES, default 3000000, idle gap after each measurement (60 ms; must be < 2^22).
REQ-005 SHALL have port Clock  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port run  input  1  level; 1 = keep scanning, 0 = stop after the current measurement.
REQ-008 SHALL have port en_mask  input  4  per-sensor enable; bit i = sensor i in the rotation.
REQ-009 SHALL have port echo_in  input  4  raw asynchronous HC-SR04 echo lines.
REQ-010 SHALL have port trig_out  output  4  trigger lines; at most one bit high at any time.
REQ-011 SHALL have port result_valid  output  1  one-cycle strobe; result_* fields valid on that cycle only.
REQ-012 SHALL have port result_timeout  output  1  qualifies result_valid: 1 = no rise or echo saturated.
REQ-013 SHALL have port result_id  output  2  sensor index of the result.
REQ-014 SHALL have port result_ticks  output  21  echo width in 20 ns clock ticks.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL pass echo_in through a 2-flop synchronizer (echo_s); only the selected sensor's echo_s bit is used; the others are ignored.
REQ-017 SHALL implement states IDLE, TRIG, WAIT_RISE, MEASURE, GUARD, one-hot or encoded.
REQ-018 IDLE: if run=1 and en_mask!=0, SHALL select the next enabled index strictly after last_id (wrapping 3->0) and enter TRIG next cycle; otherwise stay in IDLE.
REQ-019 last_id SHALL reset to 3, so the first selection is the lowest enabled index.
REQ-020 Mask changes SHALL affect only the selection in IDLE; a measurement in progress completes normally.
REQ-021 TRIG: trig_out[sel] SHALL be high for exactly TRIG_CYCLES consecutive cycles, then go low, and the FSM SHALL enter WAIT_RISE.
REQ-022 WAIT_RISE: a rising edge of echo_s (previous sample 0, current 1) SHALL enter MEASURE with the width counter = 1; a line already high on entry SHALL NOT count as a rise.
REQ-023 WAIT_RISE: after RISE_TIMEOUT cycles without a rise, SHALL emit result_valid=1, result_timeout=1, result_ticks=0, and enter GUARD.
REQ-024 MEASURE: SHALL increment the width counter each cycle echo_s=1; on the first echo_s=0 sample, SHALL emit result_valid=1, result_timeout=0, result_ticks=count, then enter GUARD.
REQ-025 Width accuracy: a raw echo high for N clocks (N < ECHO_MAX) SHALL yield result_ticks=N.
REQ-026 MEASURE: on reaching count=ECHO_MAX while echo_s is still 1, SHALL emit result_valid=1, result_timeout=1, result_ticks=ECHO_MAX, then enter GUARD; the counter SHALL never wrap.
REQ-027 GUARD: SHALL wait exactly GUARD_CYCLES cycles, update last_id=sel, then return to IDLE.
REQ-028 run=0 mid-measurement SHALL NOT abort the measurement or the guard; the FSM halts in IDLE afterwards.
REQ-029 Exactly one result_valid strobe SHALL be produced per trigger pulse; result_id SHALL equal the triggered index.
REQ-030 result_* fields SHALL hold their last values between strobes.

Reset
REQ-031 Reset=1 SHALL, on the next rising edge, force IDLE, trig_out=0, result_valid=0, result_timeout=0, result_id=0, result_ticks=0, busy=0, all counters and synchronizer flops 0, and last_id=3, regardless of the current state, including mid-trigger.

Verification
REQ-032 Bench parameters: TRIG_CYCLES=5, RISE_TIMEOUT=20, ECHO_MAX=100, GUARD_CYCLES=30. Each scenario below SHALL be covered.
REQ-033 Normal measurement: en_mask=0001, run=1, echo_in[0] high for 37 clocks, 8 clocks after trigger end -> trig_out[0] high for exactly 5 clocks; one strobe with id=0, ticks=37, timeout=0.
REQ-034 Round robin: en_mask=1010, echoes of 10 and 20 clocks -> results in order id=1 (ticks=10), id=3 (ticks=20), id=1; each trigger starts ≥30 clocks after the previous strobe.
REQ-035 No echo: en_mask=0100, echo held low -> strobe with id=2, timeout=1, ticks=0 exactly 20 clocks after trig_out[2] falls.
REQ-036 Saturation and stuck-high: echo high for 150 clocks -> timeout=1, ticks=100; echo already high at trigger end -> rise timeout, ticks=0.
REQ-037 Control edge cases: run dropped during MEASURE -> the result is still produced, then busy=0 and no further triggers; Reset pulsed during TRIG -> trig_out=0 next cycle, and after release the first trigger goes to the lowest enabled sensor.
